// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - fetch and program-load bus for instr_mem_loader
// Purpose: bundles the fetch port and the burst load port of the instruction memory.
// Ports (signals):
//   fetch_req, fetch_addr                    : fetch request from the CPU fetch stage
//   fetch_valid, instruction, fetch_err      : registered fetch response
//   load_start, load_base, load_count        : burst setup from the loader
//   load_valid, load_data, load_ready        : per-word load handshake
//   load_done, busy                          : burst status
// Modports: master = CPU/loader side, slave = memory side.
interface instr_mem_loader_if #(
   parameter int INSTR_WIDTH = 19,
   parameter int ADDR_WIDTH  = 5
);
   logic                   fetch_req;
   logic [ADDR_WIDTH-1:0]  fetch_addr;
   logic                   fetch_valid;
   logic [INSTR_WIDTH-1:0] instruction;
   logic                   fetch_err;
   logic                   load_start;
   logic [ADDR_WIDTH-1:0]  load_base;
   logic [ADDR_WIDTH:0]    load_count;
   logic                   load_valid;
   logic [INSTR_WIDTH-1:0] load_data;
   logic                   load_ready;
   logic                   load_done;
   logic                   busy;

   modport master (
      output fetch_req, fetch_addr, load_start, load_base, load_count, load_valid, load_data,
      input  fetch_valid, instruction, fetch_err, load_ready, load_done, busy
   );

   modport slave (
      input  fetch_req, fetch_addr, load_start, load_base, load_count, load_valid, load_data,
      output fetch_valid, instruction, fetch_err, load_ready, load_done, busy
   );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - instruction memory with registered fetch and burst program load
// Purpose: DEPTH-word instruction store. Fetch returns a word one cycle after the
//   request (IDLE only); a counted, handshaked burst rewrites memory at run time.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (clears memory, aborts any burst)
//   bus  : instr_mem_loader_if.slave (fetch and load signals)
// Optional feature: define INSTR_MEM_PARITY_EN to store an even-parity bit per word
//   and flag fetch_err (with instruction forced to 0) on a parity mismatch.
module instr_mem_loader #(
   parameter int INSTR_WIDTH = 19,
   parameter int DEPTH       = 32,
   parameter int ADDR_WIDTH  = 5
) (
   input logic                clk,
   input logic                rst,
   instr_mem_loader_if.slave  bus
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [INSTR_WIDTH-1:0] mem [DEPTH];
`ifdef INSTR_MEM_PARITY_EN
   logic                   par [DEPTH];
`endif

   logic [ADDR_WIDTH-1:0]  ptr, ptr_next;
   logic [ADDR_WIDTH:0]    rem, rem_next;
   logic                   wr_en;
   logic [ADDR_WIDTH:0]    count_clamped;
   logic [ADDR_WIDTH-1:0]  base_clamped;

   logic                   load_ready_c;
   logic                   load_done_c;
   logic                   busy_c;

   logic                   fetch_valid_q;
   logic [INSTR_WIDTH-1:0] instruction_q;
   logic                   fetch_err_q;

   logic                   fetch_hit;
   logic                   addr_ok;
   logic [INSTR_WIDTH-1:0] rd_word;
   logic                   par_bad;

   // Out-of-range burst setup is folded back into the legal space.
   always_comb begin
      count_clamped = (bus.load_count > DEPTH_W) ? DEPTH_W : bus.load_count;
      base_clamped  = ({1'b0, bus.load_base} >= DEPTH_W) ? '0 : bus.load_base;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         rem   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         rem   <= rem_next;
      end
   end

   always_comb begin
      state_next   = state;
      ptr_next     = ptr;
      rem_next     = rem;
      wr_en        = 1'b0;
      load_ready_c = 1'b0;
      load_done_c  = 1'b0;
      busy_c       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load_start) begin
               ptr_next   = base_clamped;
               rem_next   = count_clamped;
               state_next = (count_clamped == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            load_ready_c = 1'b1;
            busy_c       = 1'b1;
            if (bus.load_valid) begin
               wr_en    = 1'b1;
               ptr_next = (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
               rem_next = rem - 1'b1;
               if (rem == (ADDR_WIDTH+1)'(1)) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            load_done_c = 1'b1;
            busy_c      = 1'b1;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Reset clears every word so an aborted burst leaves no partial program.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
`ifdef INSTR_MEM_PARITY_EN
            par[i] <= 1'b0;
`endif
         end
      end else if (wr_en) begin
         mem[ptr] <= bus.load_data;
`ifdef INSTR_MEM_PARITY_EN
         par[ptr] <= ^bus.load_data;
`endif
      end
   end

   // Reads happen only in IDLE and writes only in LOAD, so no bypass is needed.
   assign fetch_hit = bus.fetch_req && (state == IDLE);
   assign addr_ok   = ({1'b0, bus.fetch_addr} < DEPTH_W);
   assign rd_word   = addr_ok ? mem[bus.fetch_addr] : '0;

`ifdef INSTR_MEM_PARITY_EN
   assign par_bad = addr_ok && ((^rd_word) != par[bus.fetch_addr]);
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_valid_q <= 1'b0;
         instruction_q <= '0;
         fetch_err_q   <= 1'b0;
      end else begin
         fetch_valid_q <= fetch_hit;
         if (fetch_hit) begin
            if (!addr_ok || par_bad) begin
               instruction_q <= '0;
               fetch_err_q   <= 1'b1;
            end else begin
               instruction_q <= rd_word;
               fetch_err_q   <= 1'b0;
            end
         end else begin
            // instruction holds its last value between fetches
            fetch_err_q <= 1'b0;
         end
      end
   end

   assign bus.fetch_valid = fetch_valid_q;
   assign bus.instruction = instruction_q;
   assign bus.fetch_err   = fetch_err_q;
   assign bus.load_ready  = load_ready_c;
   assign bus.load_done   = load_done_c;
   assign bus.busy        = busy_c;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Parametrised instruction memory with a registered fetch port and a burst program-load port.
- The CPU can be reprogrammed at run time instead of relying on fixed initial contents.
- Sits between the fetch stage (PC → instruction) and an external loader (testbench, UART bridge or boot ROM streamer).
- Fetch returns data one cycle after the request. Loading is a counted, handshaked burst controlled by a small FSM.

Parameters:
- INSTR_WIDTH, 19: instruction word width in bits.
- DEPTH, 32: number of words; need not be a power of two.
- ADDR_WIDTH, 5: fetch/load address width. Must satisfy 2**ADDR_WIDTH >= DEPTH.

Ports:
- clk  in  1: clock; all state changes on rising edge.
- rst  in  1: synchronous, active-high reset.
- fetch_req  in  1: fetch request, sampled each cycle.
- fetch_addr  in  ADDR_WIDTH: word address to fetch.
- fetch_valid  out  1: one-cycle pulse; instruction is valid this cycle.
- instruction  out  INSTR_WIDTH: fetched word; holds its value between fetches.
- fetch_err  out  1: qualifies fetch_valid; asserted when the address was >= DEPTH.
- load_start  in  1: starts a load burst (accepted only in IDLE).
- load_base  in  ADDR_WIDTH: first word address of the burst.
- load_count  in  ADDR_WIDTH+1: number of words in the burst (0..DEPTH).
- load_valid  in  1: loader presents load_data.
- load_data  in  INSTR_WIDTH: word to write.
- load_ready  out  1: memory accepts a word this cycle.
- load_done  out  1: one-cycle pulse when the burst completes.
- busy  out  1: high in LOAD and DONE.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All DEPTH words cleared to 0; FSM goes to IDLE.
  - Write pointer and remaining count cleared.
  - Outputs: fetch_valid=0, instruction=0, fetch_err=0, load_ready=0, load_done=0, busy=0.
  - Reset mid-burst aborts it: partial writes are discarded (memory cleared) and no load_done is issued.
- FSM states:
  - IDLE:
    - load_start=1 latches ptr=load_base and rem=load_count.
    - Next state is DONE if load_count==0, else LOAD.
  - LOAD:
    - load_ready=1, busy=1.
    - Each cycle with load_valid&&load_ready: write mem[ptr]=load_data, then ptr=(ptr==DEPTH-1)?0:ptr+1 (wraps modulo DEPTH), rem=rem-1.
    - The write that takes rem to 0 moves the FSM to DONE.
    - load_start in LOAD is ignored.
  - DONE: load_done=1, busy=1, load_ready=0 for exactly one cycle, then IDLE.
- load_count > DEPTH is clamped to DEPTH.
- load_base >= DEPTH is treated as base 0.
- Fetch:
  - Serviced only in IDLE.
  - fetch_req=1 in cycle N → in cycle N+1: fetch_valid=1, instruction=mem[fetch_addr sampled at N].
  - If fetch_addr >= DEPTH: instruction=0 (NOP) and fetch_err=1.
  - In cycles with no serviced fetch, fetch_valid=0 and fetch_err=0.
  - fetch_req in LOAD or DONE is dropped: no fetch_valid, no queueing. The requester must retry while busy=0.
- fetch_req and load_start in the same IDLE cycle: the fetch is serviced with pre-load contents and the burst starts the next cycle.
- No read/write hazard exists: writes occur only in LOAD, reads only in IDLE.
- Back-to-back fetches: a request every cycle yields a valid word every cycle at 1-cycle latency.

Optional Feature:
- Macro: INSTR_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from load_data at write time; reset clears parity bits to 0.
  - A fetch recomputes parity. On mismatch, fetch_err=1 together with fetch_valid and instruction forced to 0.
  - The width of instruction is unchanged.
- Not defined:
  - No parity storage.
  - fetch_err reflects only out-of-range addresses.

Test Plan:
- Reset, then fetch addr 0..31 → fetch_valid pulses one cycle after each request, instruction=0, fetch_err=0.
- Load base=2, count=2, data 0x58800, 0x50801 with load_valid every cycle → load_done pulses; fetch addr 2 returns 0x58800, addr 3 returns 0x50801.
- Load base=31, count=3, data 0x11111, 0x22222, 0x33333 with load_valid toggled on/off → wraps: mem[31]=0x11111, mem[0]=0x22222, mem[1]=0x33333; only valid&&ready cycles write.
- fetch_req during LOAD → no fetch_valid. Same-cycle fetch_req+load_start in IDLE → old data returned, then busy=1.
- Assert rst after one word of a 4-word burst → busy=0, load_done never pulses, all words read 0.
- DEPTH=20 build: fetch addr 25 → instruction=0, fetch_err=1. With INSTR_MEM_PARITY_EN: force a flipped stored bit → fetch_err=1.
